// File: rtl/usb_pkg.sv
// Shared types and constants for the USB receive path.
// Optional stuff-error abort is enabled with USB_RX_STUFF_CHECK_EN.
package usb_pkg;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_SYNC  = 3'd1,
    RX_DATA  = 3'd2,
    RX_ABORT = 3'd3,
    RX_EOP   = 3'd4
  } usb_rx_state_e;

  localparam int USB_STUFF_LIMIT = 6;
  localparam int USB_BYTE_BITS   = 8;

endpackage

// File: rtl/usb_bit_unstuff.sv
// Bit unstuffer: tracks the run of ones and drops stuffed zeros.
// Stuff violations are reported only with USB_RX_STUFF_CHECK_EN.
module usb_bit_unstuff
  import usb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic data_bit,
  input  logic valid,
  input  logic clear,
  output logic data_valid,
  output logic stuff_err
);

  logic [2:0] ones_cnt;
  logic       stuff_pos;

  assign stuff_pos  = ones_cnt == 3'(USB_STUFF_LIMIT);
  assign data_valid = valid && !clear && !stuff_pos;

`ifdef USB_RX_STUFF_CHECK_EN
  assign stuff_err = valid && !clear && stuff_pos && data_bit;
`else
  assign stuff_err = 1'b0;
`endif

  // While cleared the run follows the last bit, so the SYNC's final
  // one is already counted when the packet body starts.
  always_ff @(posedge clk) begin
    if (reset) begin
      ones_cnt <= 3'd0;
    end else if (valid) begin
      if (clear)
        ones_cnt <= {2'b00, data_bit};
      else if (stuff_pos || !data_bit)
        ones_cnt <= 3'd0;
      else
        ones_cnt <= ones_cnt + 3'd1;
    end
  end

endmodule

// File: rtl/usb_rx_ctrl.sv
// USB receive packet controller: SYNC hunt, unstuffing, byte framing, EOP.
// Define USB_RX_STUFF_CHECK_EN to abort packets on stuff violations.
module usb_rx_ctrl
  import usb_pkg::*;
#(
  parameter int SYNC_MIN_ZEROS = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       dec_bit,
  input  logic       dec_valid,
  input  logic       se0,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_error
);

  localparam logic [2:0] S_IDLE  = RX_IDLE;
  localparam logic [2:0] S_SYNC  = RX_SYNC;
  localparam logic [2:0] S_DATA  = RX_DATA;
  localparam logic [2:0] S_ABORT = RX_ABORT;
  localparam logic [2:0] S_EOP   = RX_EOP;

  logic [2:0] state;
  logic [2:0] zero_cnt;
  logic [3:0] bit_cnt;
  logic [7:0] shreg;
  logic [7:0] shreg_n;
  logic       line_bit;
  logic       uns_clear;
  logic       bit_ok;
  logic       stuff_err;

  assign line_bit  = dec_valid && !se0;
  assign uns_clear = state != S_DATA;
  assign shreg_n   = {dec_bit, shreg[7:1]};

  usb_bit_unstuff u_unstuff (
    .clk        (clk),
    .reset      (reset),
    .data_bit   (dec_bit),
    .valid      (line_bit),
    .clear      (uns_clear),
    .data_valid (bit_ok),
    .stuff_err  (stuff_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      zero_cnt  <= 3'd0;
      bit_cnt   <= 4'd0;
      shreg     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      rx_active <= 1'b0;
      rx_error  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_error <= 1'b0;
      if (dec_valid) begin
        unique case (state)
          S_IDLE: begin
            if (!se0 && !dec_bit) begin
              state    <= S_SYNC;
              zero_cnt <= 3'd1;
            end
          end
          S_SYNC: begin
            if (se0) begin
              state    <= S_IDLE;
              zero_cnt <= 3'd0;
            end else if (!dec_bit) begin
              if (zero_cnt != 3'd7)
                zero_cnt <= zero_cnt + 3'd1;
            end else if (int'(zero_cnt) >= SYNC_MIN_ZEROS) begin
              state     <= S_DATA;
              rx_active <= 1'b1;
              zero_cnt  <= 3'd0;
              bit_cnt   <= 4'd0;
            end else begin
              state    <= S_IDLE;
              zero_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            if (se0) begin
              // A partial byte at EOP is dropped and flagged.
              state    <= S_EOP;
              rx_error <= bit_cnt != 4'd0;
              bit_cnt  <= 4'd0;
            end else if (stuff_err) begin
              state    <= S_ABORT;
              rx_error <= 1'b1;
            end else if (bit_ok) begin
              shreg <= shreg_n;
              if (bit_cnt == 4'(USB_BYTE_BITS - 1)) begin
                rx_data  <= shreg_n;
                rx_valid <= 1'b1;
                bit_cnt  <= 4'd0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
              end
            end
          end
          S_ABORT: begin
            if (se0)
              state <= S_EOP;
          end
          S_EOP: begin
            if (!se0) begin
              state     <= S_IDLE;
              rx_active <= 1'b0;
            end
          end
          default: begin
            state     <= S_IDLE;
            rx_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_rx_ctrl.sv
// Self-checking bench for usb_rx_ctrl: vector table, directed
// corner sequences and randomized packets against a packet-level model.
module tb_usb_rx_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       dec_bit = 1'b1;
  logic       dec_valid = 1'b0;
  logic       se0 = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_error;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] got[$];
  int n_err  = 0;
  int n_both = 0;
  int n_act  = 0;

  typedef struct {
    logic       s;
    logic       b;
    logic       v;
    logic [7:0] d;
    logic       a;
    logic       e;
  } vec_t;

  vec_t tbl[$];

  typedef struct {
    logic s;
    logic b;
  } sym_t;

  always #5 clk = ~clk;

  usb_rx_ctrl #(.SYNC_MIN_ZEROS(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .dec_bit   (dec_bit),
    .dec_valid (dec_valid),
    .se0       (se0),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_active (rx_active),
    .rx_error  (rx_error)
  );

  always @(posedge clk) begin
    #1;
    if (rx_valid === 1'b1) got.push_back(rx_data);
    if (rx_error === 1'b1) n_err++;
    if (rx_valid === 1'b1 && rx_error === 1'b1) n_both++;
    if (rx_active === 1'b1) n_act++;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Caller is at a negedge; outputs for this strobe are ready on return.
  task automatic step(input logic s, input logic b);
    se0 = s;
    dec_bit = b;
    dec_valid = 1'b1;
    @(negedge clk);
    dec_valid = 1'b0;
    se0 = 1'($urandom);
    dec_bit = 1'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gstep(input logic s, input logic b);
    step(s, b);
    idle($urandom_range(0, 2));
  endtask

  task automatic clr();
    got.delete();
    n_err = 0;
    n_act = 0;
  endtask

  task automatic send_sync(input int nz);
    for (int i = 0; i < nz; i++) gstep(1'b0, 1'b0);
    gstep(1'b0, 1'b1);
  endtask

  // Sends a byte LSB-first with stuffing; run carries the ones count.
  task automatic send_byte(input logic [7:0] v, inout int run);
    for (int k = 0; k < 8; k++) begin
      gstep(1'b0, v[k]);
      run = v[k] ? run + 1 : 0;
      if (run == 6) begin
        gstep(1'b0, 1'b0);
        run = 0;
      end
    end
  endtask

  function automatic void add(input logic s, input logic b, input logic v,
                              input logic [7:0] d, input logic a,
                              input logic e);
    vec_t t;
    t.s = s; t.b = b; t.v = v; t.d = d; t.a = a; t.e = e;
    tbl.push_back(t);
  endfunction

  task automatic rand_packet(input int idx);
    sym_t       sy[$];
    sym_t       t;
    logic [7:0] exp_b[$];
    logic [7:0] v;
    int         nz, nb, part, run, exp_e;
    bit         ok;
    nz = $urandom_range(1, 8);
    ok = nz >= 5;
    exp_e = 0;
    for (int i = 0; i < nz; i++) begin
      t.s = 0; t.b = 0; sy.push_back(t);
    end
    t.s = 0; t.b = 1; sy.push_back(t);
    if (ok) begin
      nb = $urandom_range(0, 3);
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run = 1;
      for (int j = 0; j <= nb; j++) begin
        int nbits;
        v = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
        nbits = (j < nb) ? 8 : part;
        if (j < nb) exp_b.push_back(v);
        for (int k = 0; k < nbits; k++) begin
          t.s = 0; t.b = v[k]; sy.push_back(t);
          run = v[k] ? run + 1 : 0;
          if (run == 6) begin
            t.s = 0; t.b = 0; sy.push_back(t);
            run = 0;
          end
        end
      end
      exp_e = (part != 0) ? 1 : 0;
    end
    for (int i = 0; i < $urandom_range(1, 3); i++) begin
      t.s = 1; t.b = 1'($urandom); sy.push_back(t);
    end
    t.s = 0; t.b = 1; sy.push_back(t);
    clr();
    foreach (sy[i]) gstep(sy[i].s, sy[i].b);
    idle(2);
    chk($sformatf("rnd%0d.nbytes", idx), got.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < got.size(); i++)
      chk($sformatf("rnd%0d.byte%0d", idx, i), got[i], exp_b[i]);
    chk($sformatf("rnd%0d.errs", idx), n_err, exp_e);
    chk($sformatf("rnd%0d.active_seen", idx), n_act > 0, ok);
    chk($sformatf("rnd%0d.active_end", idx), rx_active, 0);
  endtask

  initial begin
    logic [7:0] cur;
    logic [7:0] pa;
    int run;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst.data", rx_data, 8'h00);
    chk("rst.valid", rx_valid, 0);
    chk("rst.active", rx_active, 0);
    chk("rst.error", rx_error, 0);

    cur = 8'h00;
    pa = 8'hA5;
    for (int i = 0; i < 7; i++) add(0, 0, 0, cur, 0, 0);
    add(0, 1, 0, cur, 1, 0);
    for (int k = 0; k < 8; k++) begin
      if (k == 7) cur = 8'hA5;
      add(0, pa[k], k == 7, cur, 1, 0);
    end
    add(1, 0, 0, cur, 1, 0);
    add(1, 1, 0, cur, 1, 0);
    add(0, 1, 0, cur, 0, 0);
    for (int i = 0; i < 7; i++) add(0, 0, 0, cur, 0, 0);
    add(0, 1, 0, cur, 1, 0);
    for (int i = 0; i < 5; i++) add(0, 1, 0, cur, 1, 0);
    add(0, 0, 0, cur, 1, 0);
    add(0, 1, 0, cur, 1, 0);
    add(0, 1, 0, cur, 1, 0);
    cur = 8'hFF;
    add(0, 1, 1, cur, 1, 0);
    add(1, 0, 0, cur, 1, 0);
    add(0, 1, 0, cur, 0, 0);

    clr();
    foreach (tbl[i]) begin
      step(tbl[i].s, tbl[i].b);
      chk($sformatf("tbl%0d.valid", i), rx_valid, tbl[i].v);
      chk($sformatf("tbl%0d.data", i), rx_data, tbl[i].d);
      chk($sformatf("tbl%0d.active", i), rx_active, tbl[i].a);
      chk($sformatf("tbl%0d.error", i), rx_error, tbl[i].e);
      idle($urandom_range(0, 2));
    end
    chk("tbl.nbytes", got.size(), 2);

    // Run of ones into the stuff position.
    clr();
    send_sync(7);
    for (int i = 0; i < 5; i++) gstep(0, 1);
    step(0, 1);
`ifdef USB_RX_STUFF_CHECK_EN
    chk("stuff.err_pulse", rx_error, 1);
`else
    chk("stuff.err_pulse", rx_error, 0);
`endif
    gstep(0, 1);
    chk("stuff.active", rx_active, 1);
    step(1, 0);
    chk("stuff.active_se0", rx_active, 1);
`ifdef USB_RX_STUFF_CHECK_EN
    chk("stuff.eop_err", rx_error, 0);
`else
    chk("stuff.eop_err", rx_error, 1);
`endif
    step(0, 1);
    chk("stuff.active_j", rx_active, 0);
    idle(2);
    chk("stuff.nbytes", got.size(), 0);
    chk("stuff.errs", n_err, 1);

    // Short SYNC rejected, then minimum SYNC accepted.
    clr();
    send_sync(3);
    for (int k = 0; k < 8; k++) gstep(0, pa[k]);
    gstep(1, 0);
    gstep(0, 1);
    idle(2);
    chk("short.active_seen", n_act, 0);
    chk("short.nbytes", got.size(), 0);
    clr();
    send_sync(5);
    run = 1;
    send_byte(8'h5A, run);
    gstep(1, 0);
    gstep(0, 1);
    idle(2);
    chk("min.nbytes", got.size(), 1);
    if (got.size() > 0) chk("min.byte", got[0], 8'h5A);
    chk("min.errs", n_err, 0);

    // Misaligned EOP.
    clr();
    send_sync(6);
    gstep(0, 1);
    gstep(0, 1);
    gstep(0, 0);
    step(1, 1);
    chk("misal.err_pulse", rx_error, 1);
    chk("misal.valid", rx_valid, 0);
    gstep(0, 1);
    idle(2);
    chk("misal.nbytes", got.size(), 0);
    chk("misal.errs", n_err, 1);
    chk("misal.active_end", rx_active, 0);

    // Reset mid-byte, then a clean packet.
    send_sync(7);
    for (int k = 0; k < 4; k++) gstep(0, 1'($urandom));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mrst.data", rx_data, 8'h00);
    chk("mrst.valid", rx_valid, 0);
    chk("mrst.active", rx_active, 0);
    chk("mrst.error", rx_error, 0);
    clr();
    send_sync(7);
    run = 1;
    send_byte(8'h3C, run);
    gstep(1, 0);
    gstep(1, 1);
    gstep(0, 1);
    idle(2);
    chk("mrst.nbytes", got.size(), 1);
    if (got.size() > 0) chk("mrst.byte", got[0], 8'h3C);
    chk("mrst.errs", n_err, 0);

    for (int p = 0; p < 40; p++) rand_packet(p);

    chk("never_valid_and_error", n_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
